// File: rtl/stride_decoder_if.sv
// Bundles the instruction, read and writeback handshakes of the stride decoder.
// The width macros get fallback values here when defines.sv has not been compiled first.
`ifndef FRAM_ADDR_RANGE
`define FRAM_ADDR_RANGE 15:0
`endif
`ifndef KRAM_ADDR_RANGE
`define KRAM_ADDR_RANGE 15:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE 31:0
`endif

interface stride_decoder_if;
    logic [`FRAM_ADDR_RANGE] stride_feature_baseaddr;
    logic [`KRAM_ADDR_RANGE] stride_kernel_baseaddr;
    logic [`DATA_RANGE]      stride_feature_chin;
    logic [`DATA_RANGE]      stride_feature_chout;
    logic [`DATA_RANGE]      stride_feature_width;
    logic [`DATA_RANGE]      stride_feature_height;
    logic [7:0]              stride_kernel_sizeh;
    logic [7:0]              stride_kernel_sizew;
    logic                    stride_has_bias;
    logic                    stride_has_relu;
    logic [`FRAM_ADDR_RANGE] stride_wb_baseaddr;
    logic [`DATA_RANGE]      stride_wb_ch_offset;
    logic                    inst_valid;
    logic                    tlast;
    logic                    decoder_ready;

    logic [`FRAM_ADDR_RANGE] fram_raddr;
    logic [`KRAM_ADDR_RANGE] kram_raddr;
    logic                    rd_valid;
    logic                    rd_bias;
    logic                    rd_last;
    logic                    pe_ready;

    logic [`FRAM_ADDR_RANGE] wb_addr;
    logic [`DATA_RANGE]      wb_ch_offset;
    logic                    wb_relu;
    logic                    wb_valid;
    logic                    wb_ready;
    logic                    layer_done;

    modport master (
        output stride_feature_baseaddr, stride_kernel_baseaddr, stride_feature_chin,
               stride_feature_chout, stride_feature_width, stride_feature_height,
               stride_kernel_sizeh, stride_kernel_sizew, stride_has_bias, stride_has_relu,
               stride_wb_baseaddr, stride_wb_ch_offset, inst_valid, tlast, pe_ready, wb_ready,
        input  decoder_ready, fram_raddr, kram_raddr, rd_valid, rd_bias, rd_last,
               wb_addr, wb_ch_offset, wb_relu, wb_valid, layer_done
    );

    modport slave (
        input  stride_feature_baseaddr, stride_kernel_baseaddr, stride_feature_chin,
               stride_feature_chout, stride_feature_width, stride_feature_height,
               stride_kernel_sizeh, stride_kernel_sizew, stride_has_bias, stride_has_relu,
               stride_wb_baseaddr, stride_wb_ch_offset, inst_valid, tlast, pe_ready, wb_ready,
        output decoder_ready, fram_raddr, kram_raddr, rd_valid, rd_bias, rd_last,
               wb_addr, wb_ch_offset, wb_relu, wb_valid, layer_done
    );
endinterface

// File: rtl/stride_decoder.sv
// Walks one convolution window (kh, kw, c) issuing FRAM/KRAM reads, an optional bias read, then a writeback.
// Optional macro STRIDE_DEC_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
`ifndef FRAM_ADDR_RANGE
`define FRAM_ADDR_RANGE 15:0
`endif
`ifndef KRAM_ADDR_RANGE
`define KRAM_ADDR_RANGE 15:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE 31:0
`endif

module stride_decoder (
    input  logic                   clk,
    input  logic                   rst_n,
    stride_decoder_if.slave        bus
`ifdef STRIDE_DEC_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);
    typedef logic [`FRAM_ADDR_RANGE] fram_t;
    typedef logic [`KRAM_ADDR_RANGE] kram_t;
    typedef logic [`DATA_RANGE]      data_t;
    typedef enum logic [1:0] {IDLE, ISSUE, BIAS, WB} state_e;

    state_e     state_q;
    fram_t      fram_q, rowStep_q, wbBase_q;
    kram_t      kram_q;
    data_t      chin_q, c_q, tap_q, lastTap_q, wbOff_q;
    logic [7:0] sizew_q, kw_q;
    logic       hasBias_q, hasRelu_q, tlast_q;
    logic       rdValid_q, rdBias_q, rdLast_q, wbValid_q, layerDone_q;

    // Only the tap count and row-wrap step are multiplied, once per instruction at latch time.
    data_t tapCount_d;
    fram_t rowStep_d;
    logic  noTaps_d, consume_d, lastTap_d, nextIsLast_d;

    assign tapCount_d   = data_t'(bus.stride_kernel_sizeh) * data_t'(bus.stride_kernel_sizew)
                          * bus.stride_feature_chin;
    assign rowStep_d    = fram_t'((bus.stride_feature_width - data_t'(bus.stride_kernel_sizew))
                          * bus.stride_feature_chin);
    assign noTaps_d     = (bus.stride_kernel_sizeh == 8'd0) || (bus.stride_kernel_sizew == 8'd0)
                          || (bus.stride_feature_chin == data_t'(0));
    assign consume_d    = rdValid_q && bus.pe_ready;
    assign lastTap_d    = (tap_q == lastTap_q);
    assign nextIsLast_d = ((tap_q + data_t'(1)) == lastTap_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fram_q      <= '0;
            rowStep_q   <= '0;
            wbBase_q    <= '0;
            kram_q      <= '0;
            chin_q      <= '0;
            c_q         <= '0;
            tap_q       <= '0;
            lastTap_q   <= '0;
            wbOff_q     <= '0;
            sizew_q     <= '0;
            kw_q        <= '0;
            hasBias_q   <= 1'b0;
            hasRelu_q   <= 1'b0;
            tlast_q     <= 1'b0;
            rdValid_q   <= 1'b0;
            rdBias_q    <= 1'b0;
            rdLast_q    <= 1'b0;
            wbValid_q   <= 1'b0;
            layerDone_q <= 1'b0;
        end else begin
            layerDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.inst_valid) begin
                        fram_q    <= bus.stride_feature_baseaddr;
                        kram_q    <= bus.stride_kernel_baseaddr;
                        rowStep_q <= rowStep_d;
                        chin_q    <= bus.stride_feature_chin;
                        sizew_q   <= bus.stride_kernel_sizew;
                        hasBias_q <= bus.stride_has_bias;
                        hasRelu_q <= bus.stride_has_relu;
                        wbBase_q  <= bus.stride_wb_baseaddr;
                        wbOff_q   <= bus.stride_wb_ch_offset;
                        tlast_q   <= bus.tlast;
                        c_q       <= '0;
                        kw_q      <= '0;
                        tap_q     <= '0;
                        lastTap_q <= tapCount_d - data_t'(1);
                        if (!noTaps_d) begin
                            state_q   <= ISSUE;
                            rdValid_q <= 1'b1;
                            rdLast_q  <= (tapCount_d == data_t'(1)) && !bus.stride_has_bias;
                        end else if (bus.stride_has_bias) begin
                            state_q   <= BIAS;
                            rdValid_q <= 1'b1;
                            rdBias_q  <= 1'b1;
                            rdLast_q  <= 1'b1;
                        end else begin
                            state_q   <= WB;
                            wbValid_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (consume_d) begin
                        kram_q <= kram_q + kram_t'(1);
                        tap_q  <= tap_q + data_t'(1);
                        if (lastTap_d) begin
                            if (hasBias_q) begin
                                state_q  <= BIAS;
                                rdBias_q <= 1'b1;
                                rdLast_q <= 1'b1;
                            end else begin
                                state_q   <= WB;
                                rdValid_q <= 1'b0;
                                rdLast_q  <= 1'b0;
                                wbValid_q <= 1'b1;
                            end
                        end else begin
                            rdLast_q <= nextIsLast_d && !hasBias_q;
                            // Channel wrap moves to the next kw; kw wrap jumps to the next kernel row.
                            if (c_q == chin_q - data_t'(1)) begin
                                c_q <= '0;
                                if (kw_q == sizew_q - 8'd1) begin
                                    kw_q   <= '0;
                                    fram_q <= fram_q + fram_t'(1) + rowStep_q;
                                end else begin
                                    kw_q   <= kw_q + 8'd1;
                                    fram_q <= fram_q + fram_t'(1);
                                end
                            end else begin
                                c_q    <= c_q + data_t'(1);
                                fram_q <= fram_q + fram_t'(1);
                            end
                        end
                    end
                end
                BIAS: begin
                    if (consume_d) begin
                        state_q   <= WB;
                        rdValid_q <= 1'b0;
                        rdBias_q  <= 1'b0;
                        rdLast_q  <= 1'b0;
                        wbValid_q <= 1'b1;
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        state_q     <= IDLE;
                        wbValid_q   <= 1'b0;
                        layerDone_q <= tlast_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef STRIDE_DEC_STALL_CNT_EN
    logic [31:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else if (rdValid_q && !bus.pe_ready && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

    assign bus.decoder_ready = (state_q == IDLE);
    assign bus.fram_raddr    = fram_q;
    assign bus.kram_raddr    = kram_q;
    assign bus.rd_valid      = rdValid_q;
    assign bus.rd_bias       = rdBias_q;
    assign bus.rd_last       = rdLast_q;
    assign bus.wb_addr       = wbBase_q;
    assign bus.wb_ch_offset  = wbOff_q;
    assign bus.wb_relu       = hasRelu_q;
    assign bus.wb_valid      = wbValid_q;
    assign bus.layer_done    = layerDone_q;
endmodule

// File: tb/tb_stride_decoder.sv
// Directed bench for stride_decoder: full window walk, stalls, empty kernel, back-to-back and reset abort.
module tb_stride_decoder;
    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;
    int   idx;
    int   stalls;

    stride_decoder_if bus ();

`ifdef STRIDE_DEC_STALL_CNT_EN
    logic [31:0] stallCnt;
    stride_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stallCnt));
`else
    stride_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int fbase, input int kbase, input int chin, input int width,
                                 input int sizeh, input int sizew, input bit bias, input bit relu,
                                 input int wbBase, input int wbOff, input bit last);
        bus.stride_feature_baseaddr = 16'(fbase);
        bus.stride_kernel_baseaddr  = 16'(kbase);
        bus.stride_feature_chin     = 32'(chin);
        bus.stride_feature_chout    = 32'd8;
        bus.stride_feature_width    = 32'(width);
        bus.stride_feature_height   = 32'd20;
        bus.stride_kernel_sizeh     = 8'(sizeh);
        bus.stride_kernel_sizew     = 8'(sizew);
        bus.stride_has_bias         = bias;
        bus.stride_has_relu         = relu;
        bus.stride_wb_baseaddr      = 16'(wbBase);
        bus.stride_wb_ch_offset     = 32'(wbOff);
        bus.tlast                   = last;
        bus.inst_valid              = 1'b1;
        step();
        bus.inst_valid = 1'b0;
    endtask

    // Reference address of tap i for the 20-wide, 3-channel, 3x3 window at origin 0.
    function automatic int expFram(input int i);
        int kh, kw, c;
        kh = i / 9;
        kw = (i / 3) % 3;
        c  = i % 3;
        return (kh * 20 + kw) * 3 + c;
    endfunction

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        bus.inst_valid = 1'b0;
        bus.tlast      = 1'b0;
        bus.pe_ready   = 1'b1;
        bus.wb_ready   = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.inst_valid = 1'b1;
        step();
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 0);
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("rst_layer_done", 32'(bus.layer_done), 0);
        checkOutput("rst_fram", 32'(bus.fram_raddr), 0);
        checkOutput("rst_kram", 32'(bus.kram_raddr), 0);
        checkOutput("rst_wb_addr", 32'(bus.wb_addr), 0);
        bus.inst_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checkOutput("rst_decoder_ready", 32'(bus.decoder_ready), 1);
        checkOutput("idle_no_read", 32'(bus.rd_valid), 0);

        $display("[TB] full window with bias, no stalls");
        applyStimulus(0, 0, 3, 20, 3, 3, 1, 1, 500, 7, 1);
        for (int i = 0; i < 28; i++) begin
            checkOutput($sformatf("win_valid_%0d", i), 32'(bus.rd_valid), 1);
            checkOutput($sformatf("win_ready_%0d", i), 32'(bus.decoder_ready), 0);
            if (i < 27) checkOutput($sformatf("win_fram_%0d", i), 32'(bus.fram_raddr), 32'(expFram(i)));
            checkOutput($sformatf("win_kram_%0d", i), 32'(bus.kram_raddr), 32'(i));
            checkOutput($sformatf("win_bias_%0d", i), 32'(bus.rd_bias), (i == 27) ? 1 : 0);
            checkOutput($sformatf("win_last_%0d", i), 32'(bus.rd_last), (i == 27) ? 1 : 0);
            step();
        end
        checkOutput("win_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("win_rd_off", 32'(bus.rd_valid), 0);
        checkOutput("win_wb_addr", 32'(bus.wb_addr), 500);
        checkOutput("win_wb_off", 32'(bus.wb_ch_offset), 7);
        checkOutput("win_wb_relu", 32'(bus.wb_relu), 1);
        step();
        checkOutput("win_wb_done", 32'(bus.wb_valid), 0);
        checkOutput("win_layer_done", 32'(bus.layer_done), 1);
        checkOutput("win_ready_back", 32'(bus.decoder_ready), 1);
        step();
        checkOutput("win_layer_done_pulse", 32'(bus.layer_done), 0);

        $display("[TB] same window with alternating pe_ready");
        bus.pe_ready = 1'b1;
        applyStimulus(0, 0, 3, 20, 3, 3, 1, 0, 600, 2, 0);
        idx = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 100 && idx < 28; cyc++) begin
            checkOutput($sformatf("stl_valid_%0d", cyc), 32'(bus.rd_valid), 1);
            if (idx < 27) checkOutput($sformatf("stl_fram_%0d", cyc), 32'(bus.fram_raddr), 32'(expFram(idx)));
            checkOutput($sformatf("stl_kram_%0d", cyc), 32'(bus.kram_raddr), 32'(idx));
            checkOutput($sformatf("stl_last_%0d", cyc), 32'(bus.rd_last), (idx == 27) ? 1 : 0);
            if (bus.pe_ready) idx++;
            else stalls++;
            step();
            bus.pe_ready = !bus.pe_ready;
        end
        bus.pe_ready = 1'b1;
        checkOutput("stl_reads_done", 32'(idx), 28);
        checkOutput("stl_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("stl_wb_addr", 32'(bus.wb_addr), 600);
`ifdef STRIDE_DEC_STALL_CNT_EN
        checkOutput("stl_stall_cnt", stallCnt, 27);
`endif
        step();
        checkOutput("stl_no_layer_done", 32'(bus.layer_done), 0);

        $display("[TB] empty kernel, writeback held by wb_ready");
        bus.wb_ready = 1'b0;
        applyStimulus(10, 10, 3, 20, 0, 3, 0, 1, 77, 4, 0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("emp_wb_valid_%0d", i), 32'(bus.wb_valid), 1);
            checkOutput($sformatf("emp_rd_valid_%0d", i), 32'(bus.rd_valid), 0);
            if (i == 5) bus.wb_ready = 1'b1;
            step();
        end
        checkOutput("emp_wb_done", 32'(bus.wb_valid), 0);
        checkOutput("emp_no_layer_done", 32'(bus.layer_done), 0);

        $display("[TB] back-to-back instructions");
        applyStimulus(40, 20, 2, 20, 1, 1, 0, 0, 300, 1, 0);
        checkOutput("b2b_a_fram0", 32'(bus.fram_raddr), 40);
        checkOutput("b2b_a_last0", 32'(bus.rd_last), 0);
        step();
        checkOutput("b2b_a_fram1", 32'(bus.fram_raddr), 41);
        checkOutput("b2b_a_kram1", 32'(bus.kram_raddr), 21);
        checkOutput("b2b_a_last1", 32'(bus.rd_last), 1);
        step();
        bus.stride_feature_baseaddr = 16'd100;
        bus.stride_kernel_baseaddr  = 16'd50;
        bus.stride_feature_chin     = 32'd1;
        bus.stride_kernel_sizeh     = 8'd1;
        bus.stride_kernel_sizew     = 8'd1;
        bus.stride_has_bias         = 1'b1;
        bus.stride_wb_baseaddr      = 16'd400;
        bus.tlast                   = 1'b1;
        bus.inst_valid              = 1'b1;
        checkOutput("b2b_a_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("b2b_a_wb_addr", 32'(bus.wb_addr), 300);
        step();
        checkOutput("b2b_ready_on_return", 32'(bus.decoder_ready), 1);
        checkOutput("b2b_a_no_layer_done", 32'(bus.layer_done), 0);
        step();
        bus.inst_valid = 1'b0;
        checkOutput("b2b_b_fram0", 32'(bus.fram_raddr), 100);
        checkOutput("b2b_b_kram0", 32'(bus.kram_raddr), 50);
        checkOutput("b2b_b_last0", 32'(bus.rd_last), 0);
        step();
        checkOutput("b2b_b_bias_kram", 32'(bus.kram_raddr), 51);
        checkOutput("b2b_b_bias_flag", 32'(bus.rd_bias), 1);
        checkOutput("b2b_b_bias_last", 32'(bus.rd_last), 1);
        step();
        checkOutput("b2b_b_wb_addr", 32'(bus.wb_addr), 400);
        checkOutput("b2b_b_pre_layer_done", 32'(bus.layer_done), 0);
        step();
        checkOutput("b2b_layer_done", 32'(bus.layer_done), 1);
        step();
        checkOutput("b2b_layer_done_pulse", 32'(bus.layer_done), 0);

        $display("[TB] reset during window issue");
        applyStimulus(0, 0, 3, 20, 3, 3, 1, 0, 500, 0, 0);
        for (int i = 0; i < 10; i++) step();
        checkOutput("abort_at_read10_kram", 32'(bus.kram_raddr), 10);
        checkOutput("abort_at_read10_fram", 32'(bus.fram_raddr), 32'(expFram(10)));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rd_valid", 32'(bus.rd_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("abort_ready", 32'(bus.decoder_ready), 1);
        checkOutput("abort_no_wb", 32'(bus.wb_valid), 0);
        applyStimulus(0, 0, 3, 20, 3, 3, 1, 0, 500, 0, 0);
        checkOutput("restart_kram0", 32'(bus.kram_raddr), 0);
        checkOutput("restart_fram0", 32'(bus.fram_raddr), 0);
        step();
        checkOutput("restart_fram1", 32'(bus.fram_raddr), 1);
        checkOutput("restart_kram1", 32'(bus.kram_raddr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/stride_decoder.md
STRIDE_DECODER -- requirements
Module: stride_decoder

Interface
REQ-001 SHALL have no parameters; widths are `FRAM_ADDR_RANGE, `KRAM_ADDR_RANGE, `DATA_RANGE (XLEN) from defines.sv.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stride_feature_baseaddr  input  FRAM_ADDR  window origin in FRAM.
REQ-005 stride_kernel_baseaddr  input  KRAM_ADDR  first kernel word for this output channel.
REQ-006 stride_feature_chin / stride_feature_chout / stride_feature_width / stride_feature_height  input  XLEN each  feature geometry.
REQ-007 stride_kernel_sizeh / stride_kernel_sizew  input  8 each  kernel rows/cols.
REQ-008 stride_has_bias / stride_has_relu  input  1 each  post-op flags.
REQ-009 stride_wb_baseaddr  input  FRAM_ADDR; stride_wb_ch_offset  input  XLEN  writeback target.
REQ-010 inst_valid  input  1; tlast  input  1 (last instruction of layer); decoder_ready  output  1.
REQ-011 fram_raddr  output  FRAM_ADDR; kram_raddr  output  KRAM_ADDR; rd_valid  output  1; rd_bias  output  1 (bias-word read, fram_raddr don't-care); rd_last  output  1 (final read of window); pe_ready  input  1.
REQ-012 wb_addr  output  FRAM_ADDR; wb_ch_offset  output  XLEN; wb_relu  output  1; wb_valid  output  1; wb_ready  input  1.
REQ-013 layer_done  output  1  one-cycle pulse.

Function
REQ-014 States SHALL be IDLE, ISSUE, BIAS, WB; decoder_ready = 1 only in IDLE.
REQ-015 IDLE: on inst_valid && decoder_ready all stride_* inputs and tlast SHALL be latched and state -> ISSUE next cycle; inputs are ignored at all other times.
REQ-016 ISSUE: reads ordered kh (outer), kw, c (inner); fram_raddr = fbase + ((kh*width)+kw)*chin + c, kram_raddr = kbase + tap index (0..N-1), N = sizeh*sizew*chin.
REQ-017 Addresses SHALL be generated incrementally by counters (+1 per c, +(width-sizew)*chin at row wrap precomputed on latch); no per-cycle multiplier; all sums truncated modulo address width.
REQ-018 rd_valid high throughout ISSUE/BIAS; a read is consumed when rd_valid && pe_ready; on !pe_ready all rd outputs SHALL hold stable.
REQ-019 First read presented the cycle after acceptance; zero bubbles between consumed reads while pe_ready=1.
REQ-020 After tap N-1 consumed: has_bias -> BIAS (one read, rd_bias=1, kram_raddr = kbase + N); else -> WB.
REQ-021 rd_last SHALL be 1 on the final read of the window (bias read if has_bias, else tap N-1).
REQ-022 N = 0 (any of sizeh, sizew, chin zero): skip ISSUE; go to BIAS if has_bias else WB.
REQ-023 WB: wb_valid=1, wb_addr=wb_baseaddr, wb_ch_offset, wb_relu=has_relu held until wb_ready; handshake cycle -> IDLE.
REQ-024 layer_done SHALL pulse the cycle after the WB handshake of an instruction latched with tlast=1.
REQ-025 New inst_valid in the cycle state returns to IDLE SHALL be accepted that same cycle (back-to-back throughput).

Reset
REQ-026 While rst_n=0: state IDLE, all counters 0, decoder_ready=1 after release, rd_valid=rd_bias=rd_last=wb_valid=layer_done=0, address/data outputs 0.
REQ-027 Reset asserted mid-ISSUE or mid-WB SHALL abort immediately; no further reads or writeback issued.

Configuration
REQ-028 Macro STRIDE_DEC_STALL_CNT_EN defined: adds output stall_cnt (32 bits) counting cycles with rd_valid && !pe_ready, saturating at all-ones, cleared only by reset.
REQ-029 Macro undefined: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 width=20, chin=3, 3x3, bias=1, pe_ready=1 -> 28 reads; fram 0,1,2..8, then 60..68, 120..128; kram 0..26 then bias at 27 with rd_bias=rd_last=1.
REQ-031 Same instruction, pe_ready toggled 1/0 each cycle -> identical address sequence, outputs stable on stalls, stall_cnt=27 (macro on).
REQ-032 sizeh=0, bias=0 -> no rd_valid; wb_valid the cycle after acceptance; wb_ready=0 for 5 cycles -> wb_valid held 6 cycles.
REQ-033 Two instructions back-to-back, second with tlast=1 -> second accepted on first WB-return cycle, layer_done single pulse after second WB only.
REQ-034 rst_n low at read 10 of REQ-030 -> rd_valid 0 immediately, decoder_ready 1 after release, next instruction restarts at tap 0.
